// File: rtl/rename_register_file_if.sv
// Issue/commit/read bundle for the rename register file.
// No backpressure: commit_en_in and issue_in are single-cycle qualifiers; reads are combinational.
interface rename_register_file_if #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int ROB_DEPTH = 8,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1
);
  localparam int AW = $clog2(NREGS);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int CW = $clog2(NREGS) + 1;

  logic [NUM_RD*AW-1:0]   rs_in;
  logic [NUM_RD*XLEN-1:0] rd_data_out;
  logic [NUM_RD*TW-1:0]   rd_tag_out;
  logic [NUM_RD-1:0]      rd_busy_out;
  logic [NUM_WR-1:0]      commit_en_in;
  logic [NUM_WR*AW-1:0]   commit_addr_in;
  logic [NUM_WR*XLEN-1:0] commit_data_in;
  logic [NUM_WR*TW-1:0]   commit_tag_in;
  logic                   issue_in;
  logic [AW-1:0]          issue_rd_in;
  logic [TW-1:0]          issue_tag_in;
  logic                   flush_in;
  logic [CW-1:0]          busy_count_out;

  modport master (
    output rs_in, commit_en_in, commit_addr_in, commit_data_in, commit_tag_in,
           issue_in, issue_rd_in, issue_tag_in, flush_in,
    input  rd_data_out, rd_tag_out, rd_busy_out, busy_count_out
  );

  modport slave (
    input  rs_in, commit_en_in, commit_addr_in, commit_data_in, commit_tag_in,
           issue_in, issue_rd_in, issue_tag_in, flush_in,
    output rd_data_out, rd_tag_out, rd_busy_out, busy_count_out
  );
endinterface

// File: rtl/rename_register_file.sv
// Architectural register file with per-register ROB rename tag and busy bit.
// Optional commit-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module rename_register_file #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int ROB_DEPTH = 8,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  rename_register_file_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int CW = $clog2(NREGS) + 1;

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [TW-1:0]    r_tag  [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_busy_cnt;

  logic [XLEN-1:0]  w_regs_nxt [NREGS];
  logic [TW-1:0]    w_tag_nxt  [NREGS];
  logic [NREGS-1:0] w_busy_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  // Commits are checked against pre-edge busy/tag; a same-cycle issue then overrides.
  always_comb begin
    w_regs_nxt = r_regs;
    w_tag_nxt  = r_tag;
    w_busy_nxt = r_busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.commit_en_in[w] && (bus.commit_addr_in[w*AW +: AW] != '0)) begin
        w_regs_nxt[bus.commit_addr_in[w*AW +: AW]] = bus.commit_data_in[w*XLEN +: XLEN];
        if (r_busy[bus.commit_addr_in[w*AW +: AW]] &&
            (r_tag[bus.commit_addr_in[w*AW +: AW]] == bus.commit_tag_in[w*TW +: TW]))
          w_busy_nxt[bus.commit_addr_in[w*AW +: AW]] = 1'b0;
      end
    end
    if (bus.flush_in) begin
      w_busy_nxt = '0;
      w_tag_nxt  = '{default: '0};
    end else if (bus.issue_in && (bus.issue_rd_in != '0)) begin
      w_tag_nxt[bus.issue_rd_in]  = bus.issue_tag_in;
      w_busy_nxt[bus.issue_rd_in] = 1'b1;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_regs     <= '{default: '0};
      r_tag      <= '{default: '0};
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_regs     <= w_regs_nxt;
      r_tag      <= w_tag_nxt;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    bus.rd_data_out = '0;
    bus.rd_tag_out  = '0;
    bus.rd_busy_out = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (bus.rs_in[p*AW +: AW] != '0) begin
        bus.rd_data_out[p*XLEN +: XLEN] = r_regs[bus.rs_in[p*AW +: AW]];
        bus.rd_tag_out[p*TW +: TW]      = r_tag[bus.rs_in[p*AW +: AW]];
        bus.rd_busy_out[p]              = r_busy[bus.rs_in[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan lets the highest-index commit port win the data.
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.commit_en_in[w] &&
              (bus.commit_addr_in[w*AW +: AW] == bus.rs_in[p*AW +: AW])) begin
            bus.rd_data_out[p*XLEN +: XLEN] = bus.commit_data_in[w*XLEN +: XLEN];
            if (bus.commit_tag_in[w*TW +: TW] == r_tag[bus.rs_in[p*AW +: AW]])
              bus.rd_busy_out[p] = 1'b0;
          end
        end
`endif
      end
    end
  end

  assign bus.busy_count_out = r_busy_cnt;
endmodule

// File: tb/tb_rename_register_file.sv
// Directed table-driven bench for rename_register_file (default parameters).
module tb_rename_register_file;
  logic clk_in;
  logic rst_in;

  rename_register_file_if #(.XLEN(32), .NREGS(32), .ROB_DEPTH(8), .NUM_RD(2), .NUM_WR(1)) bus ();

  rename_register_file #(.XLEN(32), .NREGS(32), .ROB_DEPTH(8), .NUM_RD(2), .NUM_WR(1)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic        cen;
    logic [4:0]  caddr;
    logic [31:0] cdata;
    logic [2:0]  ctag;
    logic        iss;
    logic [4:0]  ird;
    logic [2:0]  itag;
    logic        flush;
    logic [31:0] d0;
    logic [2:0]  t0;
    logic        b0;
    logic [31:0] d1;
    logic [2:0]  t1;
    logic        b1;
    logic [5:0]  cnt;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];
  int n_checks;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.commit_en_in   = 1'b0;
    bus.commit_addr_in = '0;
    bus.commit_data_in = '0;
    bus.commit_tag_in  = '0;
    bus.issue_in       = 1'b0;
    bus.issue_rd_in    = '0;
    bus.issue_tag_in   = '0;
    bus.flush_in       = 1'b0;
  endtask

  task automatic check_reads(input string tag, input logic [31:0] d0, input logic [2:0] t0,
                             input logic b0, input logic [31:0] d1, input logic [2:0] t1,
                             input logic b1, input logic [5:0] cnt);
    check({tag, " d0"},  bus.rd_data_out[31:0],  d0);
    check({tag, " t0"},  32'(bus.rd_tag_out[2:0]), 32'(t0));
    check({tag, " b0"},  32'(bus.rd_busy_out[0]), 32'(b0));
    check({tag, " d1"},  bus.rd_data_out[63:32], d1);
    check({tag, " t1"},  32'(bus.rd_tag_out[5:3]), 32'(t1));
    check({tag, " b1"},  32'(bus.rd_busy_out[1]), 32'(b1));
    check({tag, " cnt"}, 32'(bus.busy_count_out), 32'(cnt));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    //         rs0 rs1 cen caddr cdata         ctag iss ird itag fl  d0            t0 b0 d1            t1 b1 cnt
    vec[0]  = '{5'd3, 5'd5, 1'b0, 5'd0, 32'h0,    3'd0, 1'b1, 5'd3, 3'd2, 1'b0, 32'h0,    3'd2, 1'b1, 32'h0,    3'd0, 1'b0, 6'd1};
    vec[1]  = '{5'd3, 5'd0, 1'b1, 5'd3, 32'hDEAD, 3'd2, 1'b0, 5'd0, 3'd0, 1'b0, 32'hDEAD, 3'd2, 1'b0, 32'h0,    3'd0, 1'b0, 6'd0};
    vec[2]  = '{5'd4, 5'd3, 1'b0, 5'd0, 32'h0,    3'd0, 1'b1, 5'd4, 3'd1, 1'b0, 32'h0,    3'd1, 1'b1, 32'hDEAD, 3'd2, 1'b0, 6'd1};
    vec[3]  = '{5'd4, 5'd3, 1'b0, 5'd0, 32'h0,    3'd0, 1'b1, 5'd4, 3'd5, 1'b0, 32'h0,    3'd5, 1'b1, 32'hDEAD, 3'd2, 1'b0, 6'd1};
    vec[4]  = '{5'd4, 5'd4, 1'b1, 5'd4, 32'h7,    3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 32'h7,    3'd5, 1'b1, 32'h7,    3'd5, 1'b1, 6'd1};
    vec[5]  = '{5'd0, 5'd4, 1'b1, 5'd0, 32'h9,    3'd0, 1'b1, 5'd0, 3'd3, 1'b0, 32'h0,    3'd0, 1'b0, 32'h7,    3'd5, 1'b1, 6'd1};
    vec[6]  = '{5'd4, 5'd0, 1'b1, 5'd4, 32'h8,    3'd5, 1'b1, 5'd4, 3'd6, 1'b0, 32'h8,    3'd6, 1'b1, 32'h0,    3'd0, 1'b0, 6'd1};
    vec[7]  = '{5'd4, 5'd0, 1'b1, 5'd4, 32'h11,   3'd6, 1'b0, 5'd0, 3'd0, 1'b0, 32'h11,   3'd6, 1'b0, 32'h0,    3'd0, 1'b0, 6'd0};
    vec[8]  = '{5'd1, 5'd4, 1'b0, 5'd0, 32'h0,    3'd0, 1'b1, 5'd1, 3'd1, 1'b0, 32'h0,    3'd1, 1'b1, 32'h11,   3'd6, 1'b0, 6'd1};
    vec[9]  = '{5'd2, 5'd1, 1'b0, 5'd0, 32'h0,    3'd0, 1'b1, 5'd2, 3'd2, 1'b0, 32'h0,    3'd2, 1'b1, 32'h0,    3'd1, 1'b1, 6'd2};
    vec[10] = '{5'd6, 5'd1, 1'b0, 5'd0, 32'h0,    3'd0, 1'b1, 5'd6, 3'd3, 1'b0, 32'h0,    3'd3, 1'b1, 32'h0,    3'd1, 1'b1, 6'd3};
    vec[11] = '{5'd2, 5'd7, 1'b1, 5'd2, 32'h55,   3'd2, 1'b1, 5'd7, 3'd4, 1'b1, 32'h55,   3'd0, 1'b0, 32'h0,    3'd0, 1'b0, 6'd0};
    vec[12] = '{5'd7, 5'd6, 1'b0, 5'd0, 32'h0,    3'd0, 1'b1, 5'd7, 3'd4, 1'b0, 32'h0,    3'd4, 1'b1, 32'h0,    3'd0, 1'b0, 6'd1};
    vec[13] = '{5'd6, 5'd7, 1'b1, 5'd6, 32'h66,   3'd3, 1'b0, 5'd0, 3'd0, 1'b0, 32'h66,   3'd0, 1'b0, 32'h0,    3'd4, 1'b1, 6'd1};

    // Clock/reset
    rst_in = 1'b1;
    idle_inputs();
    bus.rs_in = {5'd0, 5'd5};
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    #1 check_reads("reset", 32'h0, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0, 6'd0);

    // Each vector is applied for one edge; reads are sampled afterwards with no commit active.
    for (int i = 0; i < NV; i++) begin
      bus.rs_in          = {vec[i].rs1, vec[i].rs0};
      bus.commit_en_in   = vec[i].cen;
      bus.commit_addr_in = vec[i].caddr;
      bus.commit_data_in = vec[i].cdata;
      bus.commit_tag_in  = vec[i].ctag;
      bus.issue_in       = vec[i].iss;
      bus.issue_rd_in    = vec[i].ird;
      bus.issue_tag_in   = vec[i].itag;
      bus.flush_in       = vec[i].flush;
      @(posedge clk_in);
      #1 idle_inputs();
      #1 check_reads($sformatf("v%0d", i), vec[i].d0, vec[i].t0, vec[i].b0,
                     vec[i].d1, vec[i].t1, vec[i].b1, vec[i].cnt);
    end

    // Same-cycle read of a register being committed with a matching tag (r7 busy, tag 4).
    bus.rs_in          = {5'd0, 5'd7};
    bus.commit_en_in   = 1'b1;
    bus.commit_addr_in = 5'd7;
    bus.commit_data_in = 32'h1234;
    bus.commit_tag_in  = 3'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_reads("bypass", 32'h1234, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 6'd1);
`else
    check_reads("nobypass", 32'h0, 3'd4, 1'b1, 32'h0, 3'd0, 1'b0, 6'd1);
`endif
    @(posedge clk_in);
    #1 idle_inputs();
    #1 check_reads("post_commit7", 32'h1234, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 6'd0);

    // Reset mid-operation discards that cycle's issue and commit.
    bus.rs_in          = {5'd7, 5'd5};
    bus.issue_in       = 1'b1;
    bus.issue_rd_in    = 5'd5;
    bus.issue_tag_in   = 3'd1;
    bus.commit_en_in   = 1'b1;
    bus.commit_addr_in = 5'd5;
    bus.commit_data_in = 32'hAB;
    bus.commit_tag_in  = 3'd1;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1 begin
      rst_in = 1'b0;
      idle_inputs();
    end
    #1 check_reads("midreset", 32'h0, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0, 6'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
